icb_ra_burst_master: RTL and testbench

- ICB initiator that drives the robotic-arm PL register block from inside the fabric instead of from the core.
- Takes one burst request at a time: start address, beat count, direction.
- Issues one ICB command per beat, with one transaction outstanding at most, and auto-increments the address.
- Write data arrives on a stream; read data leaves on a stream with a last-beat flag.
- Typical uses: stream 12 step counts into regs 0..11; poll 12 stepper positions from regs 12..23.

---
 rtl/icb_ra_burst_master.sv | 220 ++++++++++++++++++++++
 tb/tb_icb_ra_burst_master.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icb_ra_burst_master.sv
//==========================================================================
// icb_ra_burst_master : fabric-side ICB burst initiator for the robotic-arm
// register block. Optional response-timeout abort: ICB_RA_MST_TIMEOUT_EN.
// Revision: 1.0
//==========================================================================
`default_nettype none

module icb_ra_burst_master #(
    parameter int unsigned ADDR_STEP   = 1,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic [31:0] req_addr,
    input  logic [4:0]  req_len,
    input  logic        wd_valid,
    output logic        wd_ready,
    input  logic [31:0] wd_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_rdata,
    output logic        res_last,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        o_icb_cmd_valid,
    input  logic        o_icb_cmd_ready,
    output logic [31:0] o_icb_cmd_addr,
    output logic        o_icb_cmd_read,
    output logic [31:0] o_icb_cmd_wdata,
    input  logic        o_icb_rsp_valid,
    output logic        o_icb_rsp_ready,
    input  logic [31:0] o_icb_rsp_rdata
);

    localparam logic [31:0] C_STEP = 32'(ADDR_STEP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WLOAD = 2'd1,
        S_CMD   = 2'd2,
        S_RSP   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_res_data;
    logic [5:0]  r_cnt;
    logic        r_read;
    logic        r_res_valid;
    logic        r_res_last;
    logic        r_done;

    logic        w_cmd_valid;
    logic        w_beat_done;
    logic        w_abort;
    logic        w_last;
    logic        w_slot_free;
    logic        w_req_hs;
    logic        w_to_hit;

    assign w_last      = (r_cnt == 6'd1);
    // A slot being consumed this cycle counts as free, keeping reads at 2 cycles/beat.
    assign w_slot_free = ~r_res_valid | res_ready;
    assign w_req_hs    = req_valid & (r_state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        req_ready       = 1'b0;
        wd_ready        = 1'b0;
        w_cmd_valid     = 1'b0;
        o_icb_rsp_ready = 1'b0;
        w_beat_done     = 1'b0;
        w_abort         = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = req_read ? S_CMD : S_WLOAD;
                end
            end
            S_WLOAD: begin
                wd_ready = 1'b1;
                if (wd_valid) begin
                    w_state_nxt = S_CMD;
                end
            end
            S_CMD: begin
                o_icb_rsp_ready = 1'b1;
                w_cmd_valid     = ~r_read | w_slot_free;
                if (w_cmd_valid && o_icb_cmd_ready) begin
                    if (o_icb_rsp_valid) begin
                        w_beat_done = 1'b1;
                    end else begin
                        w_state_nxt = S_RSP;
                    end
                end
            end
            S_RSP: begin
                o_icb_rsp_ready = 1'b1;
                if (o_icb_rsp_valid) begin
                    w_beat_done = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_beat_done) begin
            w_state_nxt = w_last ? S_IDLE : (r_read ? S_CMD : S_WLOAD);
        end
        // A beat completing on the limit cycle wins over the abort.
        w_abort = w_to_hit & ((r_state == S_RSP) | w_cmd_valid) & ~w_beat_done;
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_cnt       <= 6'd0;
            r_read      <= 1'b0;
            r_done      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= 32'd0;
            r_res_last  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_req_hs) begin
                r_addr <= req_addr;
                r_cnt  <= (req_len == 5'd0) ? 6'd32 : {1'b0, req_len};
                r_read <= req_read;
            end
            if (wd_ready && wd_valid) begin
                r_wdata <= wd_data;
            end
            if (w_beat_done) begin
                r_addr <= r_addr + C_STEP;
                r_cnt  <= r_cnt - 6'd1;
                if (w_last) begin
                    r_done <= 1'b1;
                end
            end
            if (w_abort) begin
                r_done <= 1'b1;
            end
            if (w_beat_done && r_read) begin
                r_res_valid <= 1'b1;
                r_res_data  <= o_icb_rsp_rdata;
                r_res_last  <= w_last;
            end else if (r_res_valid && res_ready) begin
                r_res_valid <= 1'b0;
                r_res_last  <= 1'b0;
            end
        end
    end

`ifdef ICB_RA_MST_TIMEOUT_EN
    localparam int unsigned C_TO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [C_TO_W-1:0] r_to_cnt;
    logic              r_err;
    logic              w_wait;

    // Only cycles spent waiting on the target count; result back-pressure stalls do not.
    assign w_wait   = (r_state == S_RSP) | w_cmd_valid;
    assign w_to_hit = (r_to_cnt == C_TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_req_hs) begin
                r_err <= 1'b0;
            end else if (w_abort) begin
                r_err <= 1'b1;
            end
            if (w_req_hs || w_beat_done || w_abort) begin
                r_to_cnt <= '0;
            end else if (w_wait) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    logic [31:0] w_unused_to;
    assign w_unused_to = 32'(TIMEOUT_CYC);
    assign w_to_hit    = 1'b0;
    assign err         = 1'b0;
`endif

    assign busy            = (r_state != S_IDLE);
    assign done            = r_done;
    assign res_valid       = r_res_valid;
    assign res_rdata       = r_res_data;
    assign res_last        = r_res_last;
    assign o_icb_cmd_valid = w_cmd_valid;
    assign o_icb_cmd_addr  = r_addr;
    assign o_icb_cmd_read  = r_read;
    assign o_icb_cmd_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_icb_ra_burst_master.sv
//==========================================================================
// tb_icb_ra_burst_master : scoreboard bench with randomized ICB target,
// write-data source and result consumer.
// Revision: 1.0
//==========================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_icb_ra_burst_master;

    localparam int unsigned ADDR_STEP = 1;
    localparam int unsigned TO_CYC    = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_read = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [4:0]  req_len = 5'd0;
    logic        wd_valid = 1'b0, wd_ready;
    logic [31:0] wd_data = 32'd0;
    logic        res_valid, res_ready = 1'b0, res_last;
    logic [31:0] res_rdata;
    logic        busy, done, err;
    logic        cmd_valid, cmd_ready = 1'b0, cmd_read;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid = 1'b0, rsp_ready;
    logic [31:0] rsp_rdata = 32'd0;

    icb_ra_burst_master #(.ADDR_STEP(ADDR_STEP), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read),
        .req_addr(req_addr), .req_len(req_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_rdata(res_rdata), .res_last(res_last),
        .busy(busy), .done(done), .err(err),
        .o_icb_cmd_valid(cmd_valid), .o_icb_cmd_ready(cmd_ready), .o_icb_cmd_addr(cmd_addr),
        .o_icb_cmd_read(cmd_read), .o_icb_cmd_wdata(cmd_wdata),
        .o_icb_rsp_valid(rsp_valid), .o_icb_rsp_ready(rsp_ready), .o_icb_rsp_rdata(rsp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        rd;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } res_t;

    cmd_t        exp_cmd[$];
    res_t        exp_res[$];
    logic        exp_done[$];
    logic [31:0] wd_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int hold_cnt = 0;
    int first_wd_cyc = -1;
    int first_cmd_cyc = -1;
    int done_cyc = -1;
    bit zero_wait = 1'b0;
    bit hang = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return 32'h0000A000 + (a ^ 32'h5A000000);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic unexp(input string nm, input logic [31:0] val);
        n_vec++;
        n_err++;
        $display("FAIL %s: got transfer %0h required none", nm, val);
    endtask

    // ICB target: random accept, same-cycle or delayed response, stray rsp_valid.
    initial begin
        bit          pend;
        logic [31:0] pend_data;
        pend = 1'b0;
        pend_data = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
                cmd_ready = 1'b0;
                rsp_valid = 1'b0;
            end else if (pend) begin
                cmd_ready = 1'b0;
                rsp_valid = zero_wait || ($urandom % 3 != 0);
                rsp_rdata = pend_data;
            end else begin
                cmd_ready = !hang && (zero_wait || ($urandom % 4 != 0));
                rsp_valid = cmd_ready && (zero_wait ? !cmd_read : ($urandom % 2 == 1));
                rsp_rdata = rd_model(cmd_addr);
                if (!cmd_ready && !zero_wait && ($urandom % 5 == 0)) rsp_valid = 1'b1;
            end
            #2;
            if (rst_n) begin
                if (pend) begin
                    if (rsp_valid && rsp_ready) pend = 1'b0;
                end else if (cmd_valid && cmd_ready && !rsp_valid) begin
                    pend = 1'b1;
                    pend_data = rd_model(cmd_addr);
                end
            end
        end
    end

    // Write-data source.
    initial begin
        forever begin
            @(negedge clk);
            if (wd_q.size() > 0) begin
                wd_valid = zero_wait || ($urandom % 3 != 0);
                wd_data  = wd_q[0];
            end else begin
                wd_valid = !zero_wait && ($urandom % 4 == 0);
                wd_data  = $urandom;
            end
            #2;
            if (rst_n && wd_valid && wd_ready && wd_q.size() > 0) begin
                void'(wd_q.pop_front());
                if (first_wd_cyc < 0) first_wd_cyc = cyc;
            end
        end
    end

    // Result consumer.
    initial begin
        forever begin
            @(negedge clk);
            if (hold_cnt > 0) begin
                res_ready = 1'b0;
                hold_cnt--;
            end else begin
                res_ready = zero_wait || ($urandom % 3 != 0);
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT completes a transfer.
    initial begin
        cmd_t e;
        res_t r;
        logic d;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n) begin
                if (cmd_valid && cmd_ready) begin
                    if (first_cmd_cyc < 0) first_cmd_cyc = cyc;
                    if (exp_cmd.size() == 0) begin
                        unexp("cmd_unexpected", cmd_addr);
                    end else begin
                        e = exp_cmd.pop_front();
                        chk("cmd_addr", cmd_addr, e.addr);
                        chk("cmd_read", cmd_read, e.rd);
                        if (!e.rd) chk("cmd_wdata", cmd_wdata, e.wdata);
                    end
                end
                if (cmd_valid && cmd_read) chk("cmd_while_slot_full", res_valid & ~res_ready, 0);
                if (res_valid && res_ready) begin
                    if (exp_res.size() == 0) begin
                        unexp("res_unexpected", res_rdata);
                    end else begin
                        r = exp_res.pop_front();
                        chk("res_rdata", res_rdata, r.data);
                        chk("res_last", res_last, r.last);
                    end
                end
                if (done) begin
                    done_cyc = cyc;
                    if (exp_done.size() == 0) begin
                        unexp("done_unexpected", {31'd0, err});
                    end else begin
                        d = exp_done.pop_front();
                        chk("done_err", err, d);
                        chk("done_busy", busy, 0);
                    end
                end
            end
        end
    end

    task automatic wait_req_ready();
        int k;
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            #1;
            if (req_ready) break;
        end
        if (k == 2000) chk("req_ready_timeout", req_ready, 1);
    endtask

    task automatic issue(input logic rd, input logic [31:0] a, input logic [4:0] l, input int wbase);
        int          n;
        logic [31:0] ad, wdv;
        n = (l == 5'd0) ? 32 : int'(l);
        for (int i = 0; i < n; i++) begin
            ad  = a + 32'(i) * 32'(ADDR_STEP);
            wdv = (wbase >= 0) ? 32'(wbase + i) : $urandom;
            exp_cmd.push_back('{ad, rd, wdv});
            if (rd) exp_res.push_back('{rd_model(ad), (i == n - 1)});
            else    wd_q.push_back(wdv);
        end
        exp_done.push_back(1'b0);
        wait_req_ready();
        req_valid = 1'b1;
        req_read  = rd;
        req_addr  = a;
        req_len   = l;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_len   = 5'($urandom);
    endtask

    task automatic drain(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            #4;
            if (exp_cmd.size() == 0 && exp_res.size() == 0 && exp_done.size() == 0 && !busy) break;
        end
        if (k == budget) chk("drain_pending", exp_cmd.size() + exp_res.size() + exp_done.size(), 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_wd_ready", wd_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_last", res_last, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_addr", cmd_addr, 0);
        chk("rst_rsp_ready", rsp_ready, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int k;
        logic [31:0] ra;

        #3;
        chk_reset_outputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait write: 12 beats of 100..111 to regs 0..11.
        zero_wait = 1'b1;
        first_wd_cyc = -1;
        issue(1'b0, 32'd0, 5'd12, 100);
        drain(500);
        chk("wr_latency", done_cyc - first_wd_cyc, 24);

        // Zero-wait read of regs 12..23, target answers one cycle after cmd.
        first_cmd_cyc = -1;
        issue(1'b1, 32'd12, 5'd12, -1);
        drain(500);
        chk("rd_latency", done_cyc - first_cmd_cyc, 24);
        chk("rd_busy_after", busy, 0);

        // 32-beat write wrapping through 0.
        zero_wait = 1'b0;
        issue(1'b0, 32'hFFFF_FFFE, 5'd0, -1);
        drain(2000);

        // Result back-pressure: no second command while the slot is held.
        hold_cnt = 100000;
        issue(1'b1, 32'd12, 5'd4, -1);
        for (k = 0; k < 500; k++) begin
            if (res_valid) break;
            @(negedge clk);
            #1;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("stall_cmd_valid", cmd_valid, 0);
        end
        chk("stall_cmds_left", exp_cmd.size(), 3);
        hold_cnt = 0;
        drain(500);

        // Randomized back-to-back bursts.
        for (int b = 0; b < 40; b++) begin
            ra = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 + 32'($urandom % 16)) : $urandom;
            issue(1'($urandom), ra, 5'($urandom), -1);
        end
        drain(20000);

        // Asynchronous reset in the middle of an 8-beat read.
        zero_wait = 1'b1;
        issue(1'b1, 32'h100, 5'd8, -1);
        for (k = 0; k < 500; k++) begin
            @(negedge clk);
            #4;
            if (exp_cmd.size() <= 4) break;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        exp_cmd.delete();
        exp_res.delete();
        exp_done.delete();
        wd_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_req_ready", req_ready, 1);
        zero_wait = 1'b0;
        issue(1'b1, 32'h20, 5'd1, -1);
        drain(500);

`ifdef ICB_RA_MST_TIMEOUT_EN
        // Target never accepts: abort after TO_CYC cycles with err.
        hang = 1'b1;
        exp_done.push_back(1'b1);
        wait_req_ready();
        req_valid = 1'b1;
        req_read  = 1'b1;
        req_addr  = 32'h40;
        req_len   = 5'd3;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        cnt = 0;
        for (int j = 0; j < 100; j++) begin
            if (!cmd_valid) break;
            cnt++;
            @(negedge clk);
            #1;
        end
        chk("timeout_cycles", cnt, TO_CYC);
        chk("timeout_done", done, 1);
        chk("timeout_err", err, 1);
        hang = 1'b0;
        @(negedge clk);
        #1;
        chk("timeout_err_held", err, 1);
        chk("timeout_busy", busy, 0);
        issue(1'b0, 32'h50, 5'd2, -1);
        drain(500);
        chk("err_cleared", err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
